// File: rtl/interrupt_controller_if.sv
// CPU-facing bus, request and dispatch signals of the interrupt controller.
// The master side is the CPU/peripheral side; the slave side is the controller.
interface interrupt_controller_if;
  logic [15:0] i_Address;
  logic [7:0]  i_Bus;
  logic        i_Bus_Out;
  logic        i_Bus_In;
  logic [7:0]  o_Bus;
  logic [4:0]  i_Requests;
  logic [4:0]  o_Interrupts;
  logic        o_Wake;
  logic        i_Handle_Interrupt;
  logic [15:0] o_Vector;
  logic        o_Ack;

  modport master (
    output i_Address, i_Bus, i_Bus_Out, i_Bus_In, i_Requests, i_Handle_Interrupt,
    input  o_Bus, o_Interrupts, o_Wake, o_Vector, o_Ack
  );

  modport slave (
    input  i_Address, i_Bus, i_Bus_Out, i_Bus_In, i_Requests, i_Handle_Interrupt,
    output o_Bus, o_Interrupts, o_Wake, o_Vector, o_Ack
  );
endinterface

// File: rtl/interrupt_controller.sv
// IF/IE register pair, request edge capture and the vector dispatch handshake.
// Lower-numbered interrupts win; one IF bit is cleared per dispatch.
module interrupt_controller #(
  parameter logic [15:0] IF_ADDR  = 16'hFF0F,
  parameter logic [15:0] IE_ADDR  = 16'hFFFF,
  parameter logic [15:0] VEC_BASE = 16'h0040
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Enable,
  interrupt_controller_if.slave  bus
);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACK  = 1'b1;

  logic [4:0]  if_reg;
  logic [7:0]  ie_reg;
  logic [4:0]  req_hist_reg;
  logic [0:0]  state_reg;
  logic [15:0] vector_reg;
  logic        ack_reg;

  logic [4:0]  pending;
  logic [4:0]  lowest_onehot;
  logic [2:0]  lowest_idx;
  logic [4:0]  req_edge;
  logic [4:0]  ack_clr;
  logic [4:0]  if_next;
  logic        wr_if;
  logic        wr_ie;
  logic        dispatch_start;

  assign pending = if_reg & ie_reg[4:0];

  // Index of the lowest pending bit (highest priority); loop runs downward so bit 0 wins.
  always_comb begin
    lowest_idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) lowest_idx = 3'(i);
    end
  end

  // Isolate the lowest set bit: x & -x.
  assign lowest_onehot = pending & (~pending + 5'd1);

  // Request edges only count on enabled cycles, so disabled cycles leave history intact.
  assign req_edge       = i_Enable ? (bus.i_Requests & ~req_hist_reg) : 5'd0;
  assign wr_if          = i_Enable & bus.i_Bus_Out & (bus.i_Address == IF_ADDR);
  assign wr_ie          = i_Enable & bus.i_Bus_Out & (bus.i_Address == IE_ADDR);
  assign dispatch_start = i_Enable & bus.i_Handle_Interrupt & (state_reg == ST_IDLE);
  assign ack_clr        = dispatch_start ? lowest_onehot : 5'd0;

  // A fresh request edge beats both the acknowledge clear and a CPU write.
  assign if_next = ((wr_if ? bus.i_Bus[4:0] : if_reg) & ~ack_clr) | req_edge;

  // Register file and request history.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      if_reg       <= 5'd0;
      ie_reg       <= 8'd0;
      req_hist_reg <= 5'd0;
    end else if (i_Enable) begin
      if_reg       <= if_next;
      req_hist_reg <= bus.i_Requests;
      if (wr_ie) ie_reg <= bus.i_Bus;
    end
  end

  // Dispatch handshake: latch a vector on the strobe, release when the CPU drops it.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_reg  <= ST_IDLE;
      vector_reg <= 16'd0;
      ack_reg    <= 1'b0;
    end else if (i_Enable) begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.i_Handle_Interrupt) begin
            state_reg  <= ST_ACK;
            ack_reg    <= 1'b1;
            // An empty pending set means the dispatch was cancelled: vector 0.
            vector_reg <= (pending != 5'd0) ? (VEC_BASE + {10'd0, lowest_idx, 3'd0}) : 16'd0;
          end
        end
        default: begin
          if (!bus.i_Handle_Interrupt) begin
            state_reg <= ST_IDLE;
            ack_reg   <= 1'b0;
          end
        end
      endcase
    end
  end

  // Combinational read mux onto the OR-combined data bus.
  always_comb begin
    bus.o_Bus = 8'h00;
    if (bus.i_Bus_In) begin
      if (bus.i_Address == IF_ADDR)      bus.o_Bus = {3'b111, if_reg};
      else if (bus.i_Address == IE_ADDR) bus.o_Bus = ie_reg;
    end
  end

  assign bus.o_Interrupts = pending;
  assign bus.o_Wake       = |pending;
  assign bus.o_Vector     = vector_reg;
  assign bus.o_Ack        = ack_reg;
endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register access, request capture,
// dispatch priority, same-cycle collisions, cancelled dispatch, reset and enable gating.
module tb_interrupt_controller;
  logic clk = 1'b0;
  logic rst;
  logic en;
  int   n_total = 0;
  int   n_pass  = 0;

  interrupt_controller_if ifc ();

  interrupt_controller dut (
    .i_Clk    (clk),
    .i_Reset  (rst),
    .i_Enable (en),
    .bus      (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wr(input logic [15:0] addr, input logic [7:0] data);
    ifc.i_Address = addr;
    ifc.i_Bus     = data;
    ifc.i_Bus_Out = 1'b1;
    step();
    ifc.i_Bus_Out = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [15:0] addr, input logic [7:0] exp);
    ifc.i_Address = addr;
    ifc.i_Bus_In  = 1'b1;
    #1;
    check(tag, {8'h00, ifc.o_Bus}, {8'h00, exp});
    ifc.i_Bus_In  = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    ifc.i_Address          = 16'h0000;
    ifc.i_Bus              = 8'h00;
    ifc.i_Bus_Out          = 1'b0;
    ifc.i_Bus_In           = 1'b0;
    ifc.i_Requests         = 5'd0;
    ifc.i_Handle_Interrupt = 1'b0;
    step();
    step();
    rst = 1'b0;

    // 1. reset state
    rd_check("rst_if_read", 16'hFF0F, 8'hE0);
    rd_check("rst_ie_read", 16'hFFFF, 8'h00);
    check("rst_ints", {11'd0, ifc.o_Interrupts}, 16'h0000);
    check("rst_ack",  {15'd0, ifc.o_Ack}, 16'h0000);
    check("rst_wake", {15'd0, ifc.o_Wake}, 16'h0000);
    check("rst_vec",  ifc.o_Vector, 16'h0000);
    ifc.i_Address = 16'hFF0F;
    #1;
    check("no_strobe_bus", {8'h00, ifc.o_Bus}, 16'h0000);
    $display("txn reset: IF=E0 IE=00 ack=%0b", ifc.o_Ack);

    // 2. request capture
    wr(16'hFFFF, 8'h1F);
    rd_check("ie_read", 16'hFFFF, 8'h1F);
    ifc.i_Requests = 5'b00100;
    step();
    ifc.i_Requests = 5'b00000;
    rd_check("req_if_read", 16'hFF0F, 8'hE4);
    check("req_ints", {11'd0, ifc.o_Interrupts}, 16'h0004);
    check("req_wake", {15'd0, ifc.o_Wake}, 16'h0001);
    rd_check("unmapped_read", 16'hFF10, 8'h00);
    $display("txn request: timer edge -> IF=E4 wake=%0b", ifc.o_Wake);

    // 3. dispatch priority
    wr(16'hFF0F, 8'h16);
    rd_check("if_write_read", 16'hFF0F, 8'hF6);
    ifc.i_Handle_Interrupt = 1'b1;
    step();
    check("disp1_ack", {15'd0, ifc.o_Ack}, 16'h0001);
    check("disp1_vec", ifc.o_Vector, 16'h0048);
    rd_check("disp1_if", 16'hFF0F, 8'hF4);
    step();
    rd_check("ack_hold_if", 16'hFF0F, 8'hF4);
    check("ack_hold_ints", {11'd0, ifc.o_Interrupts}, 16'h0014);
    ifc.i_Handle_Interrupt = 1'b0;
    step();
    check("drop_ack", {15'd0, ifc.o_Ack}, 16'h0000);
    check("drop_vec_hold", ifc.o_Vector, 16'h0048);
    ifc.i_Handle_Interrupt = 1'b1;
    step();
    check("disp2_vec", ifc.o_Vector, 16'h0050);
    rd_check("disp2_if", 16'hFF0F, 8'hF0);
    ifc.i_Handle_Interrupt = 1'b0;
    step();
    $display("txn dispatch: vectors 0048 then 0050");

    // 4. write, request edge and ack clear all on bit 0 in one cycle
    wr(16'hFF0F, 8'h01);
    ifc.i_Address          = 16'hFF0F;
    ifc.i_Bus              = 8'h00;
    ifc.i_Bus_Out          = 1'b1;
    ifc.i_Requests         = 5'b00001;
    ifc.i_Handle_Interrupt = 1'b1;
    step();
    ifc.i_Bus_Out = 1'b0;
    rd_check("collide_if", 16'hFF0F, 8'hE1);
    check("collide_vec", ifc.o_Vector, 16'h0040);
    check("collide_ack", {15'd0, ifc.o_Ack}, 16'h0001);
    ifc.i_Handle_Interrupt = 1'b0;
    step();
    $display("txn collision: IF=E1 vec=%h", ifc.o_Vector);

    // 5. cancelled dispatch
    wr(16'hFF0F, 8'h00);
    rd_check("cancel_pre_if", 16'hFF0F, 8'hE0);
    ifc.i_Handle_Interrupt = 1'b1;
    step();
    check("cancel_ack", {15'd0, ifc.o_Ack}, 16'h0001);
    check("cancel_vec", ifc.o_Vector, 16'h0000);
    rd_check("cancel_if", 16'hFF0F, 8'hE0);
    ifc.i_Handle_Interrupt = 1'b0;
    step();
    ifc.i_Requests = 5'b00000;
    step();
    $display("txn cancel: vec=%h ack dropped=%0b", ifc.o_Vector, !ifc.o_Ack);

    // 6. reset in ACK, then disabled cycles
    wr(16'hFF0F, 8'h1F);
    ifc.i_Handle_Interrupt = 1'b1;
    step();
    check("pre_rst_vec", ifc.o_Vector, 16'h0040);
    wr(16'hFF0F, 8'h1F);
    rd_check("pre_rst_if", 16'hFF0F, 8'hFF);
    rst = 1'b1;
    ifc.i_Handle_Interrupt = 1'b0;
    step();
    rst = 1'b0;
    check("ack_rst_ack", {15'd0, ifc.o_Ack}, 16'h0000);
    check("ack_rst_vec", ifc.o_Vector, 16'h0000);
    rd_check("ack_rst_if", 16'hFF0F, 8'hE0);
    en = 1'b0;
    ifc.i_Requests = 5'b00010;
    step();
    step();
    rd_check("disabled_if", 16'hFF0F, 8'hE0);
    en = 1'b1;
    step();
    rd_check("reenable_if", 16'hFF0F, 8'hE2);
    check("reenable_ints", {11'd0, ifc.o_Interrupts}, 16'h0000);
    $display("txn reset/enable: IF after enable read E2");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
